axil_reg_slave: RTL and testbench

AXI4-Lite slave register file: the responder side of the AXI4-Lite master transactions used to exercise reg_core. It exposes NUM_REGS 32-bit read/write registers to the AXI bus and drives them out in parallel to fabric logic. Write and read channels run as independent FSMs, each with one transaction outstanding and full VALID/READY backpressure.

---
 rtl/axil_reg_slave.sv | 214 +++++++++++++++++++++
 tb/tb_axil_reg_slave.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_reg_slave.sv
`default_nettype none
// ============================================================================
// Module   : axil_reg_slave
// Purpose  : AXI4-Lite slave exposing NUM_REGS 32-bit read/write registers,
//            driven out in parallel on REG_OUT. Independent write and read
//            channels, one transaction outstanding each, full backpressure.
// Ports    : ACLK/ARESET (async, active-high)
//            S_AXI_AW*/W*/B*  write address, data, response channels
//            S_AXI_AR*/R*     read address, data channels
//            REG_OUT          register k at bits [32k+31:32k]
// Options  : AXIL_REG_SLAVE_SLVERR_EN - out-of-range accesses answer SLVERR
//            instead of OKAY (writes still dropped, reads still return 0).
// Revision : 1.0 - initial release
// ============================================================================
module axil_reg_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int NUM_REGS           = 4
) (
  input  logic                               ACLK,
  input  logic                               ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]      S_AXI_AWADDR,
  input  logic [2:0]                         S_AXI_AWPROT,
  input  logic                               S_AXI_AWVALID,
  output logic                               S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]      S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]    S_AXI_WSTRB,
  input  logic                               S_AXI_WVALID,
  output logic                               S_AXI_WREADY,
  output logic [1:0]                         S_AXI_BRESP,
  output logic                               S_AXI_BVALID,
  input  logic                               S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]      S_AXI_ARADDR,
  input  logic [2:0]                         S_AXI_ARPROT,
  input  logic                               S_AXI_ARVALID,
  output logic                               S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]      S_AXI_RDATA,
  output logic [1:0]                         S_AXI_RRESP,
  output logic                               S_AXI_RVALID,
  input  logic                               S_AXI_RREADY,
  output logic [C_S_AXI_DATA_WIDTH*NUM_REGS-1:0] REG_OUT
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int AW = C_S_AXI_ADDR_WIDTH;
  localparam int NB = DW / 8;

  localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXIL_REG_SLAVE_SLVERR_EN
  localparam logic [1:0] RESP_OOR  = 2'b10;
`else
  localparam logic [1:0] RESP_OOR  = 2'b00;
`endif

  typedef enum logic [0:0] {W_IDLE = 1'b0, W_RESP = 1'b1} w_state_t;
  typedef enum logic [0:0] {R_IDLE = 1'b0, R_RESP = 1'b1} r_state_t;

  w_state_t               w_state_q;
  r_state_t               r_state_q;
  logic                   awready_q, wready_q, bvalid_q;
  logic                   aw_done_q, w_done_q;
  logic [AW-1:0]          awaddr_q;
  logic [DW-1:0]          wdata_q;
  logic [NB-1:0]          wstrb_q;
  logic [1:0]             bresp_q;
  logic                   arready_q, rvalid_q;
  logic [DW-1:0]          rdata_q;
  logic [1:0]             rresp_q;
  logic [DW*NUM_REGS-1:0] regs_q;

  // Handshakes this edge; a half captured earlier is replayed from its holding
  // register so the commit sees both halves regardless of arrival order.
  logic          aw_hs_d, w_hs_d, wr_commit_d, wr_in_range_d;
  logic [AW-1:0] wr_addr_d;
  logic [DW-1:0] wr_data_d;
  logic [NB-1:0] wr_strb_d;
  logic [31:0]   wr_idx_d;

  assign aw_hs_d       = S_AXI_AWVALID & awready_q;
  assign w_hs_d        = S_AXI_WVALID & wready_q;
  assign wr_addr_d     = aw_hs_d ? S_AXI_AWADDR : awaddr_q;
  assign wr_data_d     = w_hs_d  ? S_AXI_WDATA  : wdata_q;
  assign wr_strb_d     = w_hs_d  ? S_AXI_WSTRB  : wstrb_q;
  assign wr_idx_d      = 32'(wr_addr_d[AW-1:2]);
  assign wr_in_range_d = wr_idx_d < 32'(NUM_REGS);
  assign wr_commit_d   = (w_state_q == W_IDLE) & (aw_done_q | aw_hs_d) & (w_done_q | w_hs_d);

  // Write channel and register storage.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      w_state_q <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      regs_q    <= '0;
    end else begin
      case (w_state_q)
        W_IDLE: begin
          if (wr_commit_d) begin
            for (int k = 0; k < NUM_REGS; k++) begin
              if (wr_in_range_d && (wr_idx_d == 32'(k))) begin
                for (int b = 0; b < NB; b++) begin
                  if (wr_strb_d[b]) regs_q[DW*k + 8*b +: 8] <= wr_data_d[8*b +: 8];
                end
              end
            end
            bresp_q   <= wr_in_range_d ? RESP_OKAY : RESP_OOR;
            bvalid_q  <= 1'b1;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            w_state_q <= W_RESP;
          end else begin
            if (aw_hs_d) begin
              awaddr_q  <= S_AXI_AWADDR;
              aw_done_q <= 1'b1;
              awready_q <= 1'b0;
            end else if (!aw_done_q) begin
              awready_q <= 1'b1;
            end
            if (w_hs_d) begin
              wdata_q  <= S_AXI_WDATA;
              wstrb_q  <= S_AXI_WSTRB;
              w_done_q <= 1'b1;
              wready_q <= 1'b0;
            end else if (!w_done_q) begin
              wready_q <= 1'b1;
            end
          end
        end
        W_RESP: begin
          if (S_AXI_BREADY) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            w_state_q <= W_IDLE;
          end
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  // Read path: lookup uses the pre-edge register contents, so a read on the
  // commit edge of a write to the same register returns the old value.
  logic [31:0]   rd_idx_d;
  logic [DW-1:0] rd_data_d;
  logic          rd_in_range_d;

  assign rd_idx_d      = 32'(S_AXI_ARADDR[AW-1:2]);
  assign rd_in_range_d = rd_idx_d < 32'(NUM_REGS);

  always_comb begin
    rd_data_d = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (rd_idx_d == 32'(k)) rd_data_d = regs_q[DW*k +: DW];
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      case (r_state_q)
        R_IDLE: begin
          if (S_AXI_ARVALID && arready_q) begin
            rdata_q   <= rd_data_d;
            rresp_q   <= rd_in_range_d ? RESP_OKAY : RESP_OOR;
            rvalid_q  <= 1'b1;
            arready_q <= 1'b0;
            r_state_q <= R_RESP;
          end else begin
            arready_q <= 1'b1;
          end
        end
        R_RESP: begin
          if (S_AXI_RREADY) begin
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
            r_state_q <= R_IDLE;
          end
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign REG_OUT       = regs_q;

  // Protection bits and byte-offset address bits carry no meaning here.
  logic w_unused;
  assign w_unused = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT, wr_addr_d[1:0], S_AXI_ARADDR[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_axil_reg_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_axil_reg_slave
// Purpose  : Self-checking bench for axil_reg_slave: directed scenarios plus
//            randomized accesses against an array-based register model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axil_reg_slave;

  localparam int NREG = 4;
`ifdef AXIL_REG_SLAVE_SLVERR_EN
  localparam logic [1:0] OOR = 2'b10;
`else
  localparam logic [1:0] OOR = 2'b00;
`endif

  logic         ACLK = 1'b0;
  logic         ARESET;
  logic [4:0]   S_AXI_AWADDR, S_AXI_ARADDR;
  logic [2:0]   S_AXI_AWPROT, S_AXI_ARPROT;
  logic         S_AXI_AWVALID, S_AXI_AWREADY;
  logic [31:0]  S_AXI_WDATA;
  logic [3:0]   S_AXI_WSTRB;
  logic         S_AXI_WVALID, S_AXI_WREADY;
  logic [1:0]   S_AXI_BRESP;
  logic         S_AXI_BVALID, S_AXI_BREADY;
  logic         S_AXI_ARVALID, S_AXI_ARREADY;
  logic [31:0]  S_AXI_RDATA;
  logic [1:0]   S_AXI_RRESP;
  logic         S_AXI_RVALID, S_AXI_RREADY;
  logic [127:0] REG_OUT;

  always #5 ACLK = ~ACLK;

  axil_reg_slave #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(5), .NUM_REGS(NREG)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .REG_OUT(REG_OUT)
  );

  int          n_total = 0;
  int          n_bad   = 0;
  logic [31:0] mdl [NREG];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] mdl_vec();
    logic [127:0] v;
    for (int k = 0; k < NREG; k++) v[32*k +: 32] = mdl[k];
    return v;
  endfunction

  // Full write transaction; AW and W are launched after independent delays.
  task automatic axi_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input int b_hold);
    int          idx;
    logic [31:0] nv;
    logic [1:0]  eresp;
    idx = int'(addr[4:2]);
    fork
      begin
        int t;
        repeat (aw_dly) @(negedge ACLK);
        S_AXI_AWADDR = addr; S_AXI_AWVALID = 1'b1;
        t = 0;
        while (!S_AXI_AWREADY && t < 50) begin @(negedge ACLK); t++; end
        if (t >= 50) chk("aw_timeout", S_AXI_AWREADY, 1);
        chk("bvalid_early_aw", S_AXI_BVALID, 0);
        @(posedge ACLK); @(negedge ACLK);
        S_AXI_AWVALID = 1'b0;
        chk("awready_after_hs", S_AXI_AWREADY, 0);
      end
      begin
        int t;
        repeat (w_dly) @(negedge ACLK);
        S_AXI_WDATA = data; S_AXI_WSTRB = strb; S_AXI_WVALID = 1'b1;
        t = 0;
        while (!S_AXI_WREADY && t < 50) begin @(negedge ACLK); t++; end
        if (t >= 50) chk("w_timeout", S_AXI_WREADY, 1);
        chk("bvalid_early_w", S_AXI_BVALID, 0);
        @(posedge ACLK); @(negedge ACLK);
        S_AXI_WVALID = 1'b0;
        chk("wready_after_hs", S_AXI_WREADY, 0);
      end
    join
    chk("bvalid_after_last_hs", S_AXI_BVALID, 1);
    if (idx < NREG) begin
      nv = mdl[idx];
      for (int b = 0; b < 4; b++) if (strb[b]) nv[8*b +: 8] = data[8*b +: 8];
      eresp = 2'b00;
    end else begin
      nv = 32'h0;
      eresp = OOR;
    end
    for (int i = 0; i < b_hold; i++) begin
      chk("bvalid_hold", S_AXI_BVALID, 1);
      chk("bresp_hold", S_AXI_BRESP, eresp);
      chk("awready_hold", S_AXI_AWREADY, 0);
      @(negedge ACLK);
    end
    chk("bresp", S_AXI_BRESP, eresp);
    S_AXI_BREADY = 1'b1;
    @(posedge ACLK); @(negedge ACLK);
    S_AXI_BREADY = 1'b0;
    chk("bvalid_drop", S_AXI_BVALID, 0);
    chk("awready_back", S_AXI_AWREADY, 1);
    if (idx < NREG) mdl[idx] = nv;
    chk("reg_out", REG_OUT, mdl_vec());
  endtask

  task automatic axi_read(input logic [4:0] addr, input int ar_dly, input int r_hold);
    int          idx, t;
    logic [31:0] edata;
    logic [1:0]  eresp;
    idx = int'(addr[4:2]);
    edata = (idx < NREG) ? mdl[idx] : 32'h0;
    eresp = (idx < NREG) ? 2'b00 : OOR;
    repeat (ar_dly) @(negedge ACLK);
    S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1;
    t = 0;
    while (!S_AXI_ARREADY && t < 50) begin @(negedge ACLK); t++; end
    if (t >= 50) chk("ar_timeout", S_AXI_ARREADY, 1);
    @(posedge ACLK); @(negedge ACLK);
    S_AXI_ARVALID = 1'b0;
    chk("rvalid_after_hs", S_AXI_RVALID, 1);
    chk("arready_after_hs", S_AXI_ARREADY, 0);
    for (int i = 0; i < r_hold; i++) begin
      chk("rdata_hold", S_AXI_RDATA, edata);
      chk("rvalid_hold", S_AXI_RVALID, 1);
      chk("arready_hold", S_AXI_ARREADY, 0);
      @(negedge ACLK);
    end
    chk("rdata", S_AXI_RDATA, edata);
    chk("rresp", S_AXI_RRESP, eresp);
    S_AXI_RREADY = 1'b1;
    @(posedge ACLK); @(negedge ACLK);
    S_AXI_RREADY = 1'b0;
    chk("rvalid_drop", S_AXI_RVALID, 0);
    chk("arready_back", S_AXI_ARREADY, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ARESET = 1'b1;
    S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0;
    S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;
    for (int k = 0; k < NREG; k++) mdl[k] = 32'h0;

    repeat (3) @(negedge ACLK);
    chk("rst_awready", S_AXI_AWREADY, 0);
    chk("rst_wready", S_AXI_WREADY, 0);
    chk("rst_arready", S_AXI_ARREADY, 0);
    chk("rst_bvalid", S_AXI_BVALID, 0);
    chk("rst_rvalid", S_AXI_RVALID, 0);
    chk("rst_reg_out", REG_OUT, 0);
    ARESET = 1'b0;
    @(negedge ACLK);
    chk("post_rst_awready", S_AXI_AWREADY, 1);
    chk("post_rst_arready", S_AXI_ARREADY, 1);

    // Basic fill and readback.
    for (int k = 0; k < 4; k++) axi_write(5'(4*k), 32'(k+1), 4'hF, 0, 0, 0);
    for (int k = 0; k < 4; k++) axi_read(5'(4*k), 0, 0);
    chk("reg_out_fill", REG_OUT, 128'h00000004_00000003_00000002_00000001);

    // Byte strobes.
    axi_write(5'h04, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
    axi_write(5'h04, 32'h1234_5678, 4'h5, 0, 0, 0);
    axi_read(5'h04, 0, 0);
    chk("strobe_literal", mdl[1], 32'hFF34_FF78);

    // AW leads W by three cycles, then restore 0x8 to 0x3.
    axi_write(5'h08, 32'hA5A5_A5A5, 4'hF, 0, 3, 0);
    axi_read(5'h08, 0, 0);
    axi_write(5'h08, 32'h0000_0003, 4'hF, 2, 0, 0);

    // Response backpressure.
    axi_write(5'h00, 32'hCAFE_0001, 4'hF, 1, 1, 5);
    axi_read(5'h00, 0, 5);

    // Read and write of 0xC on the same edge.
    @(negedge ACLK);
    chk("same_rdy_aw", S_AXI_AWREADY, 1);
    chk("same_rdy_ar", S_AXI_ARREADY, 1);
    S_AXI_AWADDR = 5'h0C; S_AXI_AWVALID = 1'b1;
    S_AXI_WDATA = 32'hDEAD_0000; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    S_AXI_ARADDR = 5'h0C; S_AXI_ARVALID = 1'b1;
    @(posedge ACLK); @(negedge ACLK);
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
    chk("same_bvalid", S_AXI_BVALID, 1);
    chk("same_rvalid", S_AXI_RVALID, 1);
    chk("same_rdata_old", S_AXI_RDATA, 32'h4);
    S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1;
    @(posedge ACLK); @(negedge ACLK);
    S_AXI_BREADY = 1'b0; S_AXI_RREADY = 1'b0;
    mdl[3] = 32'hDEAD_0000;
    axi_read(5'h0C, 0, 0);

    // Out-of-range index.
    axi_write(5'h10, 32'h5555_AAAA, 4'hF, 0, 1, 0);
    axi_read(5'h10, 0, 0);

    // Randomized accesses against the model.
    for (int n = 0; n < 80; n++) begin
      logic [4:0] a;
      a = {3'($urandom_range(0, 7)), 2'b00};
      if ($urandom_range(0, 1) == 1)
        axi_write(a, $urandom, 4'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      else
        axi_read(a, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    // Reset while a write response is pending.
    axi_write(5'h00, 32'h1111_2222, 4'hF, 0, 0, 0);
    @(negedge ACLK);
    S_AXI_AWADDR = 5'h04; S_AXI_AWVALID = 1'b1;
    S_AXI_WDATA = 32'h7777_8888; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    @(posedge ACLK); @(negedge ACLK);
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    chk("pre_rst_bvalid", S_AXI_BVALID, 1);
    ARESET = 1'b1;
    #1;
    chk("async_rst_bvalid", S_AXI_BVALID, 0);
    chk("async_rst_reg_out", REG_OUT, 0);
    chk("async_rst_awready", S_AXI_AWREADY, 0);
    for (int k = 0; k < NREG; k++) mdl[k] = 32'h0;
    @(negedge ACLK);
    ARESET = 1'b0;
    #1;
    chk("release_awready", S_AXI_AWREADY, 0);
    @(negedge ACLK);
    chk("release_awready_edge", S_AXI_AWREADY, 1);
    chk("release_wready_edge", S_AXI_WREADY, 1);
    chk("release_arready_edge", S_AXI_ARREADY, 1);
    chk("release_bvalid", S_AXI_BVALID, 0);
    axi_read(5'h04, 0, 0);
    axi_write(5'h08, 32'h0BAD_F00D, 4'h3, 1, 0, 1);
    axi_read(5'h08, 0, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
